// File: rtl/btn_evt.sv
// Push-button event classifier: click, double click, long press, hold repeat.
// Define BTN_EVT_REPEAT_EN to enable auto-repeat pulses while held in LONG.
module btn_evt #(
    parameter int CNT_WIDTH  = 10,
    parameter int LONG_TICKS = 500,
    parameter int DBL_TICKS  = 250,
    parameter int RPT_TICKS  = 100
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    input  logic tick_i,
    output logic click_o,
    output logic dbl_o,
    output logic long_o,
    output logic held_o,
    output logic rpt_o
);

    typedef enum logic [2:0] {
        ARM,
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } state_e;

    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] DBL_LAST  = CNT_WIDTH'(DBL_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] RPT_LAST  = CNT_WIDTH'(RPT_TICKS - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 click_d, dbl_d, long_d, held_d, rpt_d;

`ifndef BTN_EVT_REPEAT_EN
    logic unused_rpt;
    assign unused_rpt = ^RPT_LAST;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        click_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
        rpt_d   = 1'b0;
        unique case (state_q)
            ARM: begin
                if (!btn_i) state_d = IDLE;
            end
            IDLE: begin
                if (btn_i) state_d = PRESS1;
            end
            PRESS1: begin
                if (!btn_i) begin
                    state_d = WAIT2;
                end else if (tick_i) begin
                    if (cnt_q == LONG_LAST) begin
                        state_d = LONG;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT2: begin
                if (btn_i) begin
                    state_d = PRESS2;
                end else if (tick_i) begin
                    if (cnt_q == DBL_LAST) begin
                        state_d = IDLE;
                        click_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PRESS2: begin
                if (!btn_i) begin
                    state_d = IDLE;
                    dbl_d   = 1'b1;
                end else if (tick_i) begin
                    // first press is still owed a click when the second goes long
                    if (cnt_q == LONG_LAST) begin
                        state_d = LONG;
                        click_d = 1'b1;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LONG: begin
                if (!btn_i) begin
                    state_d = IDLE;
`ifdef BTN_EVT_REPEAT_EN
                end else if (tick_i) begin
                    if (cnt_q == RPT_LAST) begin
                        cnt_d = '0;
                        rpt_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = ARM;
        endcase
        if (state_d != state_q) cnt_d = '0;
        held_d = (state_d == LONG);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ARM;
            cnt_q   <= '0;
            click_o <= 1'b0;
            dbl_o   <= 1'b0;
            long_o  <= 1'b0;
            held_o  <= 1'b0;
            rpt_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            click_o <= click_d;
            dbl_o   <= dbl_d;
            long_o  <= long_d;
            held_o  <= held_d;
            rpt_o   <= rpt_d;
        end
    end

endmodule

// File: doc/btn_evt.md
Name: btn_evt

Overview:
- Push-button event classifier; sits directly downstream of the debouncer and consumes its debounced level.
- Turns one debounced active-high button level into single-cycle events: single click, double click and long press.
- Optional hold auto-repeat.
- Timing is counted in strobes of an external timebase (e.g. 1 ms tick from a prescaler), not in raw clocks.

Parameters:
- CNT_WIDTH, 10, width of the internal tick counter.
- LONG_TICKS, 500, ticks the button must stay pressed to count as a long press; 1 <= LONG_TICKS < 2^CNT_WIDTH.
- DBL_TICKS, 250, maximum ticks between the first release and the second press for a double click; 1 <= DBL_TICKS < 2^CNT_WIDTH.
- RPT_TICKS, 100, auto-repeat period in ticks; used only with the optional feature; 1 <= RPT_TICKS < 2^CNT_WIDTH.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low; one clock.
- btn_i  in  1  debounced, synchronized button level; 1 = pressed.
- tick_i  in  1  timebase strobe; one clk_i cycle wide; may be high every cycle.
- click_o  out  1  single-click pulse, 1 cycle.
- dbl_o  out  1  double-click pulse, 1 cycle.
- long_o  out  1  long-press start pulse, 1 cycle.
- held_o  out  1  level; high while in LONG.
- rpt_o  out  1  auto-repeat pulse, 1 cycle.

Behaviour:
- Reset: synchronous. While rst_ni == 0 at a clk_i edge:
  - state <= ARM, cnt <= 0.
  - All outputs <= 0.
  - Reset mid-operation aborts any pending event silently; no event pulse is emitted for it.
- FSM states: ARM, IDLE, PRESS1, WAIT2, PRESS2, LONG.
- Counter:
  - cnt clears to 0 on every state change.
  - In PRESS1, WAIT2, PRESS2 and LONG, cnt increments on each tick_i == 1.
  - "Timeout(L)" means tick_i == 1 and cnt == L-1, i.e. the L-th tick after state entry.
  - cnt never wraps: a timeout always causes a state change, or, in LONG, a reload.
- Transitions (evaluated every cycle):
  - ARM: btn_i == 0 -> IDLE. A button held through reset is therefore ignored until it is released.
  - IDLE: btn_i == 1 -> PRESS1.
  - PRESS1:
    - btn_i == 0 -> WAIT2.
    - else Timeout(LONG_TICKS) -> LONG, emit long_o.
  - WAIT2:
    - btn_i == 1 -> PRESS2.
    - else Timeout(DBL_TICKS) -> IDLE, emit click_o.
  - PRESS2:
    - btn_i == 0 -> IDLE, emit dbl_o.
    - else Timeout(LONG_TICKS) -> LONG, emit click_o and long_o in the same cycle; the first press is reported as a click.
  - LONG: btn_i == 0 -> IDLE; no pulse on release.
- Priority: a btn_i level change always beats a simultaneous timeout in the same cycle.
- Output timing:
  - All outputs are registered.
  - An event pulse is high exactly in the cycle after the clock edge that took the transition decision: 1-cycle latency from the deciding btn_i/tick_i sample.
  - held_o = registered (next_state == LONG); it rises together with long_o and falls in the cycle after the releasing sample.
- click_o, dbl_o and long_o are never high for two consecutive cycles.
- tick_i is ignored in ARM and IDLE.

Optional Feature:
- Macro: BTN_EVT_REPEAT_EN.
- Defined:
  - In LONG, Timeout(RPT_TICKS) with btn_i == 1 emits rpt_o and reloads cnt to 0 while staying in LONG.
  - The first rpt_o comes RPT_TICKS ticks after long_o, then every RPT_TICKS ticks.
  - Release has priority; no rpt_o is emitted in the releasing cycle.
- Not defined:
  - rpt_o is tied to 0.
  - cnt does not count in LONG.
  - RPT_TICKS is unused.

Test Plan:
All scenarios use LONG_TICKS=8, DBL_TICKS=4, RPT_TICKS=3, tick_i=1 every cycle.
1. btn_i held high through reset, released 10 cycles after reset deassertion, then idle 20 cycles -> no output pulses; FSM ARM -> IDLE only after the release.
2. Press 3 cycles, release, idle 10 cycles -> exactly one click_o, high 5 cycles after the release sample (4 ticks in WAIT2 plus 1 cycle of latency); dbl_o=long_o=0.
3. Press 3, release 2, press 3, release -> one dbl_o, 1 cycle after the second release; click_o=0.
4. Press held 20 cycles -> long_o and held_o rise 9 cycles after the press sample; held_o falls 1 cycle after release; click_o=dbl_o=0.
   - With BTN_EVT_REPEAT_EN: rpt_o pulses every 3 cycles after long_o until release, none in the releasing cycle.
5. Press 3, release 2, hold 10 -> click_o and long_o pulse in the same cycle; then held_o=1.
6. Release coincides with the 8th tick in PRESS1 -> WAIT2 is entered, no long_o; rst_ni pulled low during WAIT2 -> no click_o, all outputs 0 on the next edge.
